aes_enc_round: RTL and testbench

- One standard (non-final) AES encryption round on a 128-bit state: ShiftRows, then SubBytes combined with MixColumns, then AddRoundKey.
- Pipelined with a single register stage. Tagged by a valid bit.
- Sits in the encrypt datapath between the key-expansion output and the next round instance. Rounds are chained out-to-in.

---
 rtl/aes_pkg.sv | 40 ++++
 rtl/aes_sbox_mixcol.sv | 27 ++
 rtl/aes_enc_round.sv | 81 ++++++++
 tb/tb_aes_enc_round.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the encrypt round datapath.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: AES_DATA_WIDTH, the forward S-box table, xtime() and gmul3().
package aes_pkg;

  localparam int AES_DATA_WIDTH = 128;

  // Forward S-box, indexed by the input byte value.
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x (i.e. by 2) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by 3 = 2x + x.
  function automatic logic [7:0] gmul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

endpackage

// File: rtl/aes_sbox_mixcol.sv
// SubBytes followed by MixColumns for a single 32-bit state column.
// Latency: purely combinational.
// Backpressure: none; output follows input.
//
// Ports: col_in  - column bytes {row0,row1,row2,row3}, row0 in [31:24]
//        col_out - mixed column in the same byte order
module aes_sbox_mixcol
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] a, b, c, d;

  always_comb begin
    a = SBOX[col_in[31:24]];
    b = SBOX[col_in[23:16]];
    c = SBOX[col_in[15:8]];
    d = SBOX[col_in[7:0]];
    col_out[31:24] = xtime(a) ^ gmul3(b) ^ c ^ d;
    col_out[23:16] = a ^ xtime(b) ^ gmul3(c) ^ d;
    col_out[15:8]  = a ^ b ^ xtime(c) ^ gmul3(d);
    col_out[7:0]   = gmul3(a) ^ b ^ c ^ xtime(d);
  end

endmodule

// File: rtl/aes_enc_round.sv
// One non-final AES encryption round: ShiftRows, SubBytes+MixColumns, AddRoundKey.
// Latency: 1 clock from round_valid_in to round_valid_out/state_out.
// Backpressure: none; accepts a block every cycle, idle cycles hold the last result.
//
// Ports: clk, rst (async active-low), round_valid_in, state_in, key_in (only
//        [127:0] used as round key), state_out, round_valid_out.
module aes_enc_round
  import aes_pkg::*;
#(
  parameter int KEY_WIDTH  = 128,
  parameter int DATA_WIDTH = AES_DATA_WIDTH,
  parameter int ROM_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  round_valid_in,
  input  logic [DATA_WIDTH-1:0] state_in,
  input  logic [KEY_WIDTH-1:0]  key_in,
  output logic [DATA_WIDTH-1:0] state_out,
  output logic                  round_valid_out
);

  // ROM_WIDTH only steers memory-primitive mapping; it has no logic of its own.
  logic [ROM_WIDTH-1:0] rom_hint_unused;
  assign rom_hint_unused = '0;

  // Upper half of a 256-bit key port is not part of this round's key.
  if (KEY_WIDTH > 128) begin : g_key_hi
    logic key_hi_unused;
    assign key_hi_unused = ^key_in[KEY_WIDTH-1:128];
  end

  logic [127:0] sr_state;
  logic [127:0] mc_state;

  logic         vld_q, vld_d;
  logic [127:0] mc_q, mc_d;
  logic [127:0] key_q, key_d;

  // ShiftRows: byte i sits at [127-8i -: 8], s[r][c] = byte 4c+r,
  // and row r rotates left by r so s'[r][c] = s[r][(c+r) mod 4].
  always_comb begin
    sr_state = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_state[127-8*(4*c+r) -: 8] = state_in[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  for (genvar gc = 0; gc < 4; gc++) begin : g_col
    aes_sbox_mixcol u_sbox_mixcol (
      .col_in  (sr_state[127-32*gc -: 32]),
      .col_out (mc_state[127-32*gc -: 32])
    );
  end

  // The key is registered alongside the pre-key result so AddRoundKey sits
  // after the flop and both halves always come from the same input cycle.
  always_comb begin
    vld_d = round_valid_in;
    mc_d  = round_valid_in ? mc_state     : mc_q;
    key_d = round_valid_in ? key_in[127:0] : key_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
      mc_q  <= '0;
      key_q <= '0;
    end else begin
      vld_q <= vld_d;
      mc_q  <= mc_d;
      key_q <= key_d;
    end
  end

  assign state_out       = mc_q ^ key_q;
  assign round_valid_out = vld_q;

endmodule

// File: tb/tb_aes_enc_round.sv
// Self-checking bench for aes_enc_round: FIPS-197 vectors, corner cases,
// reset behaviour and random traffic against an algebraic reference model.
module tb_aes_enc_round;

  logic         clk = 1'b0;
  logic         rst;
  logic         round_valid_in;
  logic [127:0] state_in;
  logic [127:0] key_in;
  logic [127:0] state_out;
  logic         round_valid_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sbox_ref [256];

  always #5 clk = ~clk;

  aes_enc_round dut (
    .clk             (clk),
    .rst             (rst),
    .round_valid_in  (round_valid_in),
    .state_in        (state_in),
    .key_in          (key_in),
    .state_out       (state_out),
    .round_valid_out (round_valid_out)
  );

  // GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] w = {v, v};
    return w[15-n -: 8];
  endfunction

  // S-box from its definition: inverse in GF(2^8) then the affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (a != 0 && gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Reference round on a 4x4 byte matrix.
  function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key);
    logic [7:0] s  [4][4];
    logic [7:0] t  [4][4];
    logic [7:0] base [4];
    logic [127:0] res;
    base = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int i = 0; i < 16; i++) s[i%4][i/4] = st[127-8*i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = sbox_ref[s[r][(c+r)%4]];
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        logic [7:0] acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gf_mul(base[(k-r+4)%4], t[k][c]);
        res[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return res ^ key;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] exp_state;
    logic         exp_vld;
    logic [127:0] d_state, d_key;

    build_sbox();

    rst            = 1'b0;
    round_valid_in = 1'b0;
    state_in       = '0;
    key_in         = '0;
    #2;
    check("reset_state_out", state_out, '0);
    check("reset_valid_out", 128'(round_valid_out), 128'(1'b0));

    // Valid traffic while held in reset must not be captured.
    round_valid_in = 1'b1;
    state_in       = rnd128();
    key_in         = rnd128();
    tick();
    check("in_reset_state_out", state_out, '0);
    check("in_reset_valid_out", 128'(round_valid_out), 128'(1'b0));

    rst            = 1'b1;
    state_in       = 128'h00102030405060708090a0b0c0d0e0f0;
    key_in         = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    round_valid_in = 1'b1;
    tick();
    check("fips_r1_state", state_out, 128'h89d810e8855ace682d1843d8cb128fe4);
    check("fips_r1_valid", 128'(round_valid_out), 128'(1'b1));

    state_in = 128'h89d810e8855ace682d1843d8cb128fe4;
    key_in   = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    tick();
    check("fips_r2_state", state_out, 128'h4915598f55e5d7a0daca94fa1f0a63f7);
    check("fips_r2_valid", 128'(round_valid_out), 128'(1'b1));

    state_in = '0;
    key_in   = '0;
    tick();
    check("zero_key0", state_out, {16{8'h63}});
    key_in = '1;
    tick();
    check("zero_key1", state_out, {16{8'h9c}});

    // Valid gap 1,0,0: output holds the last valid result.
    d_state   = rnd128();
    d_key     = rnd128();
    exp_state = ref_round(d_state, d_key);
    state_in  = d_state;
    key_in    = d_key;
    tick();
    check("gap_first_state", state_out, exp_state);
    check("gap_first_valid", 128'(round_valid_out), 128'(1'b1));
    for (int i = 0; i < 2; i++) begin
      round_valid_in = 1'b0;
      state_in       = rnd128();
      key_in         = rnd128();
      tick();
      check("gap_hold_state", state_out, exp_state);
      check("gap_hold_valid", 128'(round_valid_out), 128'(1'b0));
    end

    // Asynchronous reset between edges with a block in flight.
    round_valid_in = 1'b1;
    state_in       = rnd128();
    key_in         = rnd128();
    tick();
    check("pre_reset_valid", 128'(round_valid_out), 128'(1'b1));
    state_in = rnd128();
    key_in   = rnd128();
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_state", state_out, '0);
    check("async_reset_valid", 128'(round_valid_out), 128'(1'b0));
    tick();
    check("held_reset_state", state_out, '0);
    round_valid_in = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    check("post_reset_state", state_out, '0);
    check("post_reset_valid", 128'(round_valid_out), 128'(1'b0));
    tick();
    check("post_reset_state2", state_out, '0);

    // Random traffic, mostly valid with occasional bubbles.
    exp_state = '0;
    for (int i = 0; i < 60; i++) begin
      d_state        = rnd128();
      d_key          = rnd128();
      round_valid_in = ($urandom_range(0, 3) != 0);
      state_in       = d_state;
      key_in         = d_key;
      exp_vld        = round_valid_in;
      if (round_valid_in) exp_state = ref_round(d_state, d_key);
      tick();
      check("rand_state", state_out, exp_state);
      check("rand_valid", 128'(round_valid_out), 128'(exp_vld));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
